demux_router_1x4: RTL and testbench
===================================

// Module: demux_router_1x4
// PURPOSE
//  Registered, flow-controlled 1-to-4 stream router; sequential successor to the combinational 1x4 demux.
//  Steers a valid/ready input stream to one of four output channels selected by {s1,s0}.
//  The select is locked for a whole packet. Each output has a 1-deep holding register.
//  Sits between a packet source and four independent consumers.
// PARAMETERS
//  DW        8   data width per beat
//  CNT_W     16  width of per-output beat counters (DEMUX_STATS_EN only)
// PORTS
//  clk        in   1       rising-edge clock, the only clock
//  rst        in   1       synchronous, active-high reset
//  i_valid    in   1       input beat valid
//  i_ready    out  1       input beat accepted when i_valid & i_ready
//  i_data     in   DW      input beat payload
//  i_last     in   1       last beat of packet
//  s1,s0      in   1,1     destination select {s1,s0}; sampled on the first beat of a packet only
//  y_valid    out  4       per-output valid; bit n = channel yn
//  y_ready    in   4       per-output ready
//  y_data     out  4*DW    channel n at [n*DW +: DW]
//  y_last     out  4       per-output last flag
//  y_count    out  4*CNT_W beats delivered per channel (DEMUX_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE, dest=0, y_valid=0, y_data=0, y_last=0, y_count=0.
//    i_ready=0 during reset; it is combinational and is 0 whenever rst=1.
//  - FSM IDLE: first beat sets dest={s1,s0}.
//    - If that beat has i_last=1: stay in IDLE.
//    - Otherwise go to LOCKED.
//  - FSM LOCKED: dest is held; s1/s0 are ignored.
//    - The accepted beat with i_last=1 returns the FSM to IDLE.
//  - Target channel t: {s1,s0} in IDLE, dest in LOCKED.
//  - i_ready = !rst & (!y_valid[t] | y_ready[t]). Full-throughput pass-through is supported.
//  - Accepted beat: written to slot t at the next edge, so latency is 1 cycle. y_valid[t] rises next cycle.
//  - Slot n clears when y_valid[n] & y_ready[n] and no new beat targets n in the same cycle.
//  - Simultaneous drain + fill of the same slot: the new beat wins and y_valid stays 1.
//  - Non-target slots drain independently. No head-of-line coupling except through i_ready.
//  - y_data/y_last hold stable while y_valid=1 & y_ready=0 (AXI-style stability).
//  - Changing s1/s0 mid-packet has no effect. The new value is used only after the last beat is accepted.
//  - Reset mid-packet: all slots are flushed with no output beats and the FSM returns to IDLE.
//  - y_valid never asserts on more than one channel per accepted beat. No beat is duplicated or dropped.
// CONFIGURATION
//  Macro DEMUX_STATS_EN.
//  - Defined: y_count port exists. Counter n increments on y_valid[n] & y_ready[n].
//    Saturates at 2^CNT_W-1 (no wrap). Cleared by rst.
//  - Undefined: no y_count port, no counter logic. All other behaviour is identical.
// STRUCTURE
//  Package demux_pkg holds:
//  - localparam NUM_OUT=4, SEL_W=2
//  - typedef logic [SEL_W-1:0] sel_t
//  - typedef enum {IDLE, LOCKED} rtr_state_t
//  Sub-module demux_out_slot (param DW): 1-deep valid/ready holding register with fill/drain logic.
//  - Instantiated 4x via generate.
//  Top level holds the FSM, dest register, i_ready mux and optional counters.
// TESTING
//  1. rst=1 for 2 cycles -> y_valid=0000, i_ready=0. After release with y_ready=1111: i_ready=1.
//  2. Single-beat packet: {s1,s0}=10, i_data=8'hA5, i_last=1, y_ready=1111
//     -> next cycle y_valid=0100, y_data[23:16]=A5, y_last[2]=1.
//  3. 3-beat packet to {s1,s0}=01, data 11,22,33; toggle s1,s0 to 11 on beat 2
//     -> all three beats appear on y1 in order, y3 never valid.
//  4. Backpressure: y_ready[0]=0, send 2 beats to ch0
//     -> first beat held stable, i_ready=0 on the second.
//     Raise y_ready[0] -> second beat accepted in the same cycle (drain+fill), y_valid[0] stays 1.
//  5. rst asserted mid 4-beat packet after beat 2
//     -> next cycle y_valid=0000, FSM IDLE; new packet to ch3 routes correctly.
//  6. DEMUX_STATS_EN with CNT_W=4: send 20 beats to ch2 -> y_count ch2 = 15 (saturated), others 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1x4 flow-controlled stream router.
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } rtr_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-deep valid/ready holding register for a single router output channel.
module demux_out_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill,
    input  logic [DW-1:0] fill_data,
    input  logic          fill_last,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          last
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (fill) begin
            // A fill in the same cycle as a drain wins, so valid stays high.
            valid <= 1'b1;
            data  <= fill_data;
            last  <= fill_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_router_1x4.sv
// Registered 1-to-4 valid/ready stream router with per-packet destination lock.
// Optional per-channel delivered-beat counters are built when DEMUX_STATS_EN is defined.
module demux_router_1x4
    import demux_pkg::*;
#(
    parameter int DW = 8
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DW-1:0]         i_data,
    input  logic                  i_last,
    input  logic                  s1,
    input  logic                  s0,
    output logic [NUM_OUT-1:0]    y_valid,
    input  logic [NUM_OUT-1:0]    y_ready,
    output logic [NUM_OUT*DW-1:0] y_data,
    output logic [NUM_OUT-1:0]    y_last
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0] y_count
`endif
);

    rtr_state_t          state, state_next;
    sel_t                dest, sel, tgt;
    logic                accept;
    logic [NUM_OUT-1:0]  fill;

    assign sel = {s1, s0};
    // The live select only matters on the first beat; afterwards the locked dest steers.
    assign tgt = (state == IDLE) ? sel : dest;

    assign i_ready = !rst && (!y_valid[tgt] || y_ready[tgt]);
    assign accept  = i_valid && i_ready;

    // NOTE: every signal written in always_comb gets a default first, otherwise
    // paths that skip the assignment infer a latch.
    always_comb begin
        fill      = '0;
        fill[tgt] = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dest  <= '0;
        end else begin
            state <= state_next;
            if (accept && state == IDLE) begin
                dest <= sel;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !i_last) state_next = LOCKED;
            LOCKED:  if (accept && i_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar n = 0; n < NUM_OUT; n++) begin : g_slot
        demux_out_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .fill      (fill[n]),
            .fill_data (i_data),
            .fill_last (i_last),
            .ready     (y_ready[n]),
            .valid     (y_valid[n]),
            .data      (y_data[n*DW +: DW]),
            .last      (y_last[n])
        );
    end

`ifdef DEMUX_STATS_EN
    for (genvar n = 0; n < NUM_OUT; n++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        // Saturating: the counter sticks at all-ones instead of wrapping.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (y_valid[n] && y_ready[n] && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign y_count[n*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_demux_router_1x4.sv
// Self-checking bench for demux_router_1x4: vector table, directed corner sequences,
// and randomized traffic against a queue-based scoreboard. Counter test needs DEMUX_STATS_EN.
module tb_demux_router_1x4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  i_data;
    logic        i_last;
    logic        s1, s0;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic [31:0] y_data;
    logic [3:0]  y_last;
`ifdef DEMUX_STATS_EN
    logic [15:0] y_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_router_1x4 #(
        .DW(8)
`ifdef DEMUX_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .s1      (s1),
        .s0      (s0),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data),
        .y_last  (y_last)
`ifdef DEMUX_STATS_EN
        , .y_count (y_count)
`endif
    );

    typedef struct {
        logic        r;
        logic        iv;
        logic [1:0]  s;
        logic [7:0]  d;
        logic        l;
        logic [3:0]  yr;
        logic        e_ir;
        logic [3:0]  e_yv;
        logic [31:0] e_yd;
        logic [3:0]  e_yl;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    vec_t  vecs[11];
    beat_t q[4][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge; outputs are checked at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic l, input logic [3:0] yr);
        @(posedge clk);
        #1;
        rst = r; i_valid = v; {s1, s0} = s; i_data = d; i_last = l; y_ready = yr;
        @(negedge clk);
    endtask

    function automatic logic [31:0] vmask(input logic [3:0] v);
        logic [31:0] m;
        for (int n = 0; n < 4; n++) m[n*8 +: 8] = {8{v[n]}};
        return m;
    endfunction

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; s1 = 1'b0; s0 = 1'b0; y_ready = 4'hf;

        //          r  iv s  d      l  yr    ir  yv     yd            yl
        vecs[0]  = '{1, 0, 0, 8'h00, 0, 4'hf, 0, 4'h0, 32'h0,        4'h0};
        vecs[1]  = '{1, 0, 0, 8'h00, 0, 4'hf, 0, 4'h0, 32'h0,        4'h0};
        vecs[2]  = '{0, 0, 0, 8'h00, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0};
        vecs[3]  = '{0, 1, 2, 8'hA5, 1, 4'hf, 1, 4'h0, 32'h0,        4'h0};
        vecs[4]  = '{0, 0, 0, 8'h00, 0, 4'hf, 1, 4'h4, 32'h00A50000, 4'h4};
        vecs[5]  = '{0, 0, 0, 8'h00, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0};
        vecs[6]  = '{0, 1, 0, 8'h3C, 1, 4'h0, 1, 4'h0, 32'h0,        4'h0};
        vecs[7]  = '{0, 0, 0, 8'h00, 0, 4'h0, 0, 4'h1, 32'h0000003C, 4'h1};
        vecs[8]  = '{0, 0, 1, 8'h00, 0, 4'h0, 1, 4'h1, 32'h0000003C, 4'h1};
        vecs[9]  = '{0, 0, 0, 8'h00, 0, 4'h1, 1, 4'h1, 32'h0000003C, 4'h1};
        vecs[10] = '{0, 0, 0, 8'h00, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0};

        for (int k = 0; k < 11; k++) begin
            step(vecs[k].r, vecs[k].iv, vecs[k].s, vecs[k].d, vecs[k].l, vecs[k].yr);
            check($sformatf("vec%0d i_ready", k), 64'(i_ready), 64'(vecs[k].e_ir));
            check($sformatf("vec%0d y_valid", k), 64'(y_valid), 64'(vecs[k].e_yv));
            check($sformatf("vec%0d y_data", k), 64'(y_data & vmask(vecs[k].e_yv)), 64'(vecs[k].e_yd));
            check($sformatf("vec%0d y_last", k), 64'(y_last & vecs[k].e_yv), 64'(vecs[k].e_yl));
        end

        // 3-beat packet to ch1; select changes mid-packet must be ignored.
        step(0, 1, 1, 8'h11, 0, 4'hf);
        check("pkt3 b1 i_ready", 64'(i_ready), 64'd1);
        step(0, 1, 3, 8'h22, 0, 4'hf);
        check("pkt3 b1 y_valid", 64'(y_valid), 64'h2);
        check("pkt3 b1 y_data", 64'(y_data[15:8]), 64'h11);
        check("pkt3 b1 y_last", 64'(y_last[1]), 64'd0);
        step(0, 1, 3, 8'h33, 1, 4'hf);
        check("pkt3 b2 y_valid", 64'(y_valid), 64'h2);
        check("pkt3 b2 y_data", 64'(y_data[15:8]), 64'h22);
        step(0, 0, 3, 8'h00, 0, 4'hf);
        check("pkt3 b3 y_valid", 64'(y_valid), 64'h2);
        check("pkt3 b3 y_data", 64'(y_data[15:8]), 64'h33);
        check("pkt3 b3 y_last", 64'(y_last[1]), 64'd1);
        step(0, 0, 0, 8'h00, 0, 4'hf);
        check("pkt3 idle y_valid", 64'(y_valid), 64'h0);

        // Backpressure on ch0, then simultaneous drain + fill.
        step(0, 1, 0, 8'h44, 0, 4'he);
        check("bp b1 i_ready", 64'(i_ready), 64'd1);
        step(0, 1, 2, 8'h55, 1, 4'he);
        check("bp stall y_valid", 64'(y_valid), 64'h1);
        check("bp stall y_data", 64'(y_data[7:0]), 64'h44);
        check("bp stall i_ready", 64'(i_ready), 64'd0);
        step(0, 1, 2, 8'h55, 1, 4'he);
        check("bp hold y_data", 64'(y_data[7:0]), 64'h44);
        check("bp hold i_ready", 64'(i_ready), 64'd0);
        step(0, 1, 2, 8'h55, 1, 4'hf);
        check("bp release i_ready", 64'(i_ready), 64'd1);
        check("bp release y_data", 64'(y_data[7:0]), 64'h44);
        step(0, 0, 0, 8'h00, 0, 4'he);
        check("bp refill y_valid", 64'(y_valid), 64'h1);
        check("bp refill y_data", 64'(y_data[7:0]), 64'h55);
        check("bp refill y_last", 64'(y_last[0]), 64'd1);
        step(0, 0, 0, 8'h00, 0, 4'hf);
        step(0, 0, 0, 8'h00, 0, 4'hf);
        check("bp drained y_valid", 64'(y_valid), 64'h0);

        // Reset in the middle of a 4-beat packet to ch1.
        step(0, 1, 1, 8'h61, 0, 4'hf);
        step(0, 1, 1, 8'h62, 0, 4'hf);
        step(1, 1, 1, 8'h63, 0, 4'hf);
        check("midrst i_ready", 64'(i_ready), 64'd0);
        check("midrst pre y_valid", 64'(y_valid), 64'h2);
        step(0, 1, 3, 8'h77, 1, 4'hf);
        check("midrst flush y_valid", 64'(y_valid), 64'h0);
        check("midrst new i_ready", 64'(i_ready), 64'd1);
        step(0, 0, 0, 8'h00, 0, 4'hf);
        check("midrst ch3 y_valid", 64'(y_valid), 64'h8);
        check("midrst ch3 y_data", 64'(y_data[31:24]), 64'h77);
        check("midrst ch3 y_last", 64'(y_last[3]), 64'd1);

        // Randomized traffic against a scoreboard: each channel holds at most one
        // queued beat; the packet lock is tracked as "inside a packet" plus its dest.
        begin
            logic       in_pkt;
            logic [1:0] mdest;
            logic [1:0] t;
            logic [3:0] e_yv;
            logic       e_ir;
            step(1, 0, 0, 8'h00, 0, 4'hf);
            in_pkt = 1'b0;
            mdest  = 2'd0;
            for (int n = 0; n < 4; n++) q[n].delete();
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk);
                #1;
                rst     = ($urandom_range(0, 149) == 0);
                i_valid = ($urandom_range(0, 3) != 0);
                {s1, s0} = 2'($urandom_range(0, 3));
                i_data  = 8'($urandom);
                i_last  = ($urandom_range(0, 2) == 0);
                y_ready = 4'($urandom);
                @(negedge clk);

                for (int n = 0; n < 4; n++) e_yv[n] = (q[n].size() != 0);
                t    = in_pkt ? mdest : {s1, s0};
                e_ir = !rst && (!e_yv[t] || y_ready[t]);
                check("rnd i_ready", 64'(i_ready), 64'(e_ir));
                check("rnd y_valid", 64'(y_valid), 64'(e_yv));
                for (int n = 0; n < 4; n++) begin
                    if (e_yv[n]) begin
                        check($sformatf("rnd y_data%0d", n), 64'(y_data[n*8 +: 8]), 64'(q[n][0].d));
                        check($sformatf("rnd y_last%0d", n), 64'(y_last[n]), 64'(q[n][0].l));
                    end
                end

                if (rst) begin
                    for (int n = 0; n < 4; n++) q[n].delete();
                    in_pkt = 1'b0;
                end else begin
                    for (int n = 0; n < 4; n++) begin
                        if (e_yv[n] && y_ready[n]) void'(q[n].pop_front());
                    end
                    if (i_valid && e_ir) begin
                        q[t].push_back('{d: i_data, l: i_last});
                        if (!in_pkt) mdest = {s1, s0};
                        in_pkt = !i_last;
                    end
                end
            end
        end

`ifdef DEMUX_STATS_EN
        // 20 beats to ch2 with a 4-bit counter: ch2 saturates at 15, others stay 0.
        step(1, 0, 0, 8'h00, 0, 4'hf);
        for (int i = 0; i < 20; i++) step(0, 1, 2, 8'(i), 1, 4'hf);
        step(0, 0, 0, 8'h00, 0, 4'hf);
        step(0, 0, 0, 8'h00, 0, 4'hf);
        check("stats y_count", 64'(y_count), 64'h0F00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
